// File: rtl/act_sparse_feeder_if.sv
// Handshake and result bus between an activation source and the sparse feeder.
// master: the side that presents dense groups and load requests.
// slave: the feeder itself.
interface act_sparse_feeder_if #(
  parameter int bw     = 4,
  parameter int cnt_bw = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [4*bw-1:0]     in_group;
  logic                load_req;
  logic                load;
  logic                execute;
  logic [2*bw-1:0]     activation_flat;
  logic [3:0]          activation_index_flat;
  logic                group_last;
  logic [cnt_bw-1:0]   group_count;
  logic [cnt_bw-1:0]   beat_count;

  modport master (
    output in_valid, in_group, load_req,
    input  in_ready, load, execute, activation_flat, activation_index_flat,
           group_last, group_count, beat_count
  );

  modport slave (
    input  in_valid, in_group, load_req,
    output in_ready, load, execute, activation_flat, activation_index_flat,
           group_last, group_count, beat_count
  );
endinterface

// File: rtl/act_sparse_feeder.sv
// Compresses a group of four dense activations into one or two beats that
// carry only the nonzero elements (two slots per beat) plus their indices.
// Weight-load pulses are slotted in between groups and never overlap a beat.
//
// state | meaning
// IDLE  | accepting groups / load requests; first beat of a group is emitted
// SPLIT | second beat of a 3- or 4-nonzero group is being emitted
module act_sparse_feeder #(
  parameter int bw     = 4,
  parameter int cnt_bw = 16
) (
  input logic                clk,
  input logic                reset,
  act_sparse_feeder_if.slave bus
);

  typedef enum logic {IDLE, SPLIT} state_t;

  localparam logic [cnt_bw-1:0] CNT_MAX = {cnt_bw{1'b1}};

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic              load_q, load_d;
  logic              exec_q, exec_d;
  logic              last_q, last_d;
  logic [2*bw-1:0]   act_q, act_d;
  logic [3:0]        idx_q, idx_d;
  logic [2*bw-1:0]   hold_act_q, hold_act_d;
  logic [3:0]        hold_idx_q, hold_idx_d;
  logic [cnt_bw-1:0] grp_cnt_q, grp_cnt_d;
  logic [cnt_bw-1:0] beat_cnt_q, beat_cnt_d;

  logic              in_ready_w;
  logic              accept;
  logic [bw-1:0]     pk_val [4];
  logic [1:0]        pk_idx [4];
  logic [2:0]        nz_cnt;

  // A pending load blocks acceptance so its pulse cannot collide with a beat.
  assign in_ready_w = reset & (state_q == IDLE) & ~bus.load_req & ~pend_q;
  assign accept     = bus.in_valid & in_ready_w;

  // Pack the nonzero elements of the incoming group in ascending index order.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pk_val[i] = '0;
      pk_idx[i] = '0;
    end
    nz_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.in_group[i*bw +: bw] != '0) begin
        pk_val[nz_cnt[1:0]] = bus.in_group[i*bw +: bw];
        pk_idx[nz_cnt[1:0]] = 2'(i);
        nz_cnt              = nz_cnt + 3'd1;
      end
    end
  end

  // Next-state, beat formation, load scheduling and saturating counters.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    load_d     = 1'b0;
    exec_d     = 1'b0;
    last_d     = 1'b0;
    act_d      = '0;
    idx_d      = '0;
    hold_act_d = hold_act_q;
    hold_idx_d = hold_idx_q;
    grp_cnt_d  = grp_cnt_q;
    beat_cnt_d = beat_cnt_q;

    case (state_q)
      IDLE: begin
        load_d = bus.load_req | pend_q;
        pend_d = 1'b0;
        if (accept) begin
          exec_d = 1'b1;
          act_d  = {pk_val[1], pk_val[0]};
          idx_d  = {pk_idx[1], pk_idx[0]};
          if (nz_cnt >= 3'd3) begin
            state_d    = SPLIT;
            last_d     = 1'b0;
            hold_act_d = {pk_val[3], pk_val[2]};
            hold_idx_d = {pk_idx[3], pk_idx[2]};
          end else begin
            last_d = 1'b1;
          end
        end
      end
      SPLIT: begin
        state_d = IDLE;
        exec_d  = 1'b1;
        last_d  = 1'b1;
        act_d   = hold_act_q;
        idx_d   = hold_idx_q;
        // Deferred until the split group has fully drained.
        if (bus.load_req) pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (accept && (grp_cnt_q != CNT_MAX)) grp_cnt_d = grp_cnt_q + 1'b1;
    if (exec_d && (beat_cnt_q != CNT_MAX)) beat_cnt_d = beat_cnt_q + 1'b1;
  end

  // State and output registers; reset drops any in-flight second beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      load_q     <= 1'b0;
      exec_q     <= 1'b0;
      last_q     <= 1'b0;
      act_q      <= '0;
      idx_q      <= '0;
      hold_act_q <= '0;
      hold_idx_q <= '0;
      grp_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      load_q     <= load_d;
      exec_q     <= exec_d;
      last_q     <= last_d;
      act_q      <= act_d;
      idx_q      <= idx_d;
      hold_act_q <= hold_act_d;
      hold_idx_q <= hold_idx_d;
      grp_cnt_q  <= grp_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.in_ready              = in_ready_w;
  assign bus.load                  = load_q;
  assign bus.execute               = exec_q;
  assign bus.group_last            = last_q;
  assign bus.activation_flat       = act_q;
  assign bus.activation_index_flat = idx_q;
  assign bus.group_count           = grp_cnt_q;
  assign bus.beat_count            = beat_cnt_q;

endmodule

// File: tb/tb_act_sparse_feeder.sv
// Bench for act_sparse_feeder: directed scenarios followed by random traffic,
// checked every cycle against a queue-based model of the expected output stream.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_act_sparse_feeder;

  logic clk;
  logic reset;

  act_sparse_feeder_if #(.bw(4), .cnt_bw(16)) bus ();
  act_sparse_feeder_if #(.bw(4), .cnt_bw(4))  sbus ();

  act_sparse_feeder #(.bw(4), .cnt_bw(16)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  act_sparse_feeder #(.bw(4), .cnt_bw(4))  u_sat (.clk(clk), .reset(reset), .bus(sbus));

  assign sbus.in_valid = bus.in_valid;
  assign sbus.in_group = bus.in_group;
  assign sbus.load_req = bus.load_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         ex;
    bit         ld;
    logic [7:0] act;
    logic [3:0] idx;
    bit         last;
  } rec_t;

  rec_t fut[$];
  rec_t cur;
  int   grp_m;
  int   beat_m;
  int   checks;
  int   failures;

  function automatic rec_t idle_rec();
    rec_t r;
    r.ex = 0; r.ld = 0; r.act = '0; r.idx = '0; r.last = 0;
    return r;
  endfunction

  // Expected beats for one accepted group, derived from the list of nonzeros.
  function automatic void push_beats(input logic [15:0] g);
    logic [3:0] vals[$];
    logic [1:0] ixs[$];
    rec_t r;
    for (int i = 0; i < 4; i++) begin
      if (g[i*4 +: 4] != 4'd0) begin
        vals.push_back(g[i*4 +: 4]);
        ixs.push_back(2'(i));
      end
    end
    if (vals.size() == 0) begin
      r = idle_rec();
      r.ex = 1; r.last = 1;
      fut.push_back(r);
    end else begin
      for (int b = 0; b < vals.size(); b += 2) begin
        r = idle_rec();
        r.ex = 1;
        r.act[3:0] = vals[b];
        r.idx[1:0] = ixs[b];
        if (b + 1 < vals.size()) begin
          r.act[7:4] = vals[b+1];
          r.idx[3:2] = ixs[b+1];
        end
        r.last = (b + 2 >= vals.size());
        fut.push_back(r);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    int sat_g, sat_b;
    sat_g = (grp_m > 15) ? 15 : grp_m;
    sat_b = (beat_m > 15) ? 15 : beat_m;
    chk("execute",    32'(bus.execute), 32'(cur.ex));
    chk("load",       32'(bus.load), 32'(cur.ld));
    chk("group_last", 32'(bus.group_last), 32'(cur.last));
    chk("act_flat",   32'(bus.activation_flat), 32'(cur.act));
    chk("idx_flat",   32'(bus.activation_index_flat), 32'(cur.idx));
    chk("group_count", 32'(bus.group_count), grp_m);
    chk("beat_count",  32'(bus.beat_count), beat_m);
    chk("sat_group_count", 32'(sbus.group_count), sat_g);
    chk("sat_beat_count",  32'(sbus.beat_count), sat_b);
  endtask

  // One clock cycle: drive at the negedge, check, then advance the model at the posedge.
  task automatic step(input logic v, input logic [15:0] g, input logic lr);
    logic exp_ready;
    bit   has_ld;
    bus.in_valid = v;
    bus.in_group = g;
    bus.load_req = lr;
    exp_ready = (fut.size() == 0) && !lr;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    chk_outputs();
    @(posedge clk);
    if (v && exp_ready) begin
      push_beats(g);
      grp_m++;
    end
    if (lr) begin
      has_ld = 0;
      foreach (fut[i]) if (fut[i].ld) has_ld = 1;
      if (!has_ld) begin
        rec_t r;
        r = idle_rec();
        r.ld = 1;
        fut.push_back(r);
      end
    end
    if (fut.size() > 0) cur = fut.pop_front();
    else cur = idle_rec();
    if (cur.ex) beat_m++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_group = '0;
    bus.load_req = 1'b0;
    fut.delete();
    cur    = idle_rec();
    grp_m  = 0;
    beat_m = 0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [15:0] rand_group();
    logic [15:0] g;
    g = '0;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 1) g[i*4 +: 4] = 4'($urandom_range(1, 15));
    return g;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_group = '0;
    bus.load_req = 1'b0;
    cur = idle_rec();
    @(negedge clk);
    do_reset();

    // Two nonzeros -> single beat.
    step(1'b1, 16'h0503, 1'b0);
    #1;
    chk("ex1_act",  32'(bus.activation_flat), 32'h53);
    chk("ex1_idx",  32'(bus.activation_index_flat), 32'b1000);
    chk("ex1_last", 32'(bus.group_last), 32'd1);
    step(1'b0, 16'h0000, 1'b0);

    // Four nonzeros -> two beats, acceptance blocked during the first.
    step(1'b1, 16'h7654, 1'b0);
    #1;
    chk("ex2_b1_act",  32'(bus.activation_flat), 32'h54);
    chk("ex2_b1_idx",  32'(bus.activation_index_flat), 32'b0100);
    chk("ex2_b1_last", 32'(bus.group_last), 32'd0);
    step(1'b1, 16'h1111, 1'b0);
    #1;
    chk("ex2_b2_act",  32'(bus.activation_flat), 32'h76);
    chk("ex2_b2_idx",  32'(bus.activation_index_flat), 32'b1110);
    chk("ex2_b2_last", 32'(bus.group_last), 32'd1);
    step(1'b1, 16'h1111, 1'b0);
    step(1'b0, 16'h0000, 1'b0);

    // Back-to-back all-zero groups.
    for (int i = 0; i < 6; i++) step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);

    // Load requested while a split group is draining.
    step(1'b1, 16'h9876, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    #1;
    chk("split_load_pulse", 32'(bus.load), 32'd1);
    chk("split_load_noexe", 32'(bus.execute), 32'd0);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h0300, 1'b1);
    step(1'b1, 16'h0300, 1'b0);
    step(1'b0, 16'h0000, 1'b0);

    // Reset pulsed while the second beat is outstanding.
    step(1'b1, 16'h1234, 1'b0);
    do_reset();
    step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);

    // Saturation of the 4-bit counters.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 16'h0010, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("sat_grp_15",  32'(sbus.group_count), 32'd15);
    chk("sat_beat_15", 32'(sbus.beat_count), 32'd15);
    chk("wide_grp_20", 32'(bus.group_count), 32'd20);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 3) != 0), rand_group(), ($urandom_range(0, 9) == 0));
    end
    step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/act_sparse_feeder.md
ACT_SPARSE_FEEDER -- requirements
Module: act_sparse_feeder

Interface
REQ-001 Parameter bw, default 4, activation element width in bits.
REQ-002 Parameter cnt_bw, default 16, width of the group and beat statistics counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  dense activation group present on in_group.
REQ-006 in_ready  output  1  feeder accepts in_group this cycle.
REQ-007 in_group  input  4*bw  four dense activations; element i at bits [i*bw +: bw].
REQ-008 load_req  input  1  single-cycle request to emit a weight-load pulse downstream.
REQ-009 load  output  1  weight-load pulse to the downstream sparse row.
REQ-010 execute  output  1  compressed beat valid on activation_flat and activation_index_flat.
REQ-011 activation_flat  output  2*bw  slot0 at [bw-1:0], slot1 at [2*bw-1:bw].
REQ-012 activation_index_flat  output  4  slot0 index at [1:0], slot1 index at [3:2].
REQ-013 group_last  output  1  qualifies execute; high on the final beat of a group.
REQ-014 group_count  output  cnt_bw  number of groups accepted, saturating.
REQ-015 beat_count  output  cnt_bw  number of execute beats emitted, saturating.

Function
REQ-016 Handshake: a group is accepted in a cycle where in_valid and in_ready are both high; in_group is sampled only then.
REQ-017 The element test is "nonzero" (any bit set); k denotes the nonzero count of the accepted group (0..4).
REQ-018 Nonzero elements are packed in ascending index order; the lowest-index nonzero element goes to slot0.
REQ-019 k=0: one beat, both slot values 0, both slot indices 0, group_last=1.
REQ-020 k=1: one beat, slot0 holds the element and its index, slot1 value 0 and index 0, group_last=1.
REQ-021 k=2: one beat, both slots filled, group_last=1.
REQ-022 k=3 or k=4: two beats; first beat holds the two lowest-index nonzeros with group_last=0; second beat holds the remainder (k=3: slot1 value 0, index 0) with group_last=1.
REQ-023 The FSM has states IDLE and SPLIT; IDLE->SPLIT on acceptance with k>=3; SPLIT->IDLE unconditionally after one cycle.
REQ-024 Latency: the first beat is registered and appears with execute=1 in the cycle after acceptance; the second beat appears one cycle later.
REQ-025 in_ready = 1 only in IDLE with load_req low; in_ready = 0 in SPLIT and in any cycle where load_req is high.
REQ-026 Throughput: one group per cycle when k<=2; a group with k>=3 blocks acceptance for exactly one cycle.
REQ-027 load_req sampled high in IDLE produces load=1 in the next cycle for exactly one cycle; no group is accepted in the load_req cycle.
REQ-028 load_req high in SPLIT is held pending and issues load one cycle after the return to IDLE; it never interleaves with a split group.
REQ-029 execute and load are never high in the same cycle.
REQ-030 When no beat is emitted, execute=0, group_last=0, and activation_flat and activation_index_flat are held at 0.
REQ-031 group_count increments on each acceptance; beat_count increments on each execute; both saturate at 2^cnt_bw-1 and never wrap.

Reset
REQ-032 While reset=0: state=IDLE, pending load cleared, in_ready=0, and load, execute, group_last, activation_flat, activation_index_flat, group_count and beat_count all 0.
REQ-033 Reset asserted in SPLIT discards the second beat; after release, the first accepted group is processed as new.
REQ-034 in_ready rises in the first cycle after reset release.

Verification
REQ-035 Group {a3..a0}={0,5,0,3}, bw=4 -> next cycle: execute=1, group_last=1, activation_flat=0x53, activation_index_flat=4'b1000.
REQ-036 Group {7,6,5,4} -> beat1: 0x54, idx 4'b0100, last=0; beat2: 0x76, idx 4'b1110, last=1; in_ready=0 during beat1.
REQ-037 All-zero group -> one beat: activation_flat=0, idx=0, last=1; back-to-back all-zero groups accepted every cycle, so beat_count equals group_count.
REQ-038 load_req asserted during SPLIT -> second beat completes, then load=1 for one cycle, with execute=0 in that cycle.
REQ-039 Reset pulsed during SPLIT -> no second beat, counters cleared, in_ready=1 in the first cycle after release.
REQ-040 cnt_bw=4 with 20 single-beat groups -> group_count and beat_count both saturate at 15.
